// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback source encoding and default core widths
package riscv_pkg;

    localparam int XLEN_DEF = 16;
    localparam int NREG_DEF = 8;

    // Encoding 3 is left undefined on purpose; wb_stage treats it as an error.
    typedef enum logic [1:0] {
        WB_ALU          = 2'd0,
        WB_MEM          = 2'd1,
        WB_PC_PLUS_FOUR = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-load busy bits and outstanding-load counter
module wb_scoreboard #(
    parameter int NREG            = 8,
    parameter int MAX_OUTSTANDING = 2,
    localparam int RW             = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    input  logic [RW-1:0]   issue_rd_i,
    output logic            issue_ready_o,
    input  logic            rsp_valid_i,
    input  logic [RW-1:0]   rsp_rd_i,
    output logic            rsp_err_o,
    output logic [NREG-1:0] busy_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] count_q;
    logic          issue_fire;
    logic          rsp_dec;

    assign issue_ready_o = (count_q < CW'(MAX_OUTSTANDING)) &&
                           ((issue_rd_i == '0) || !busy_o[issue_rd_i]);
    assign issue_fire    = issue_valid_i && issue_ready_o;

    // Stray responses are still flagged but never drive the counter below zero.
    assign rsp_err_o = rsp_valid_i &&
                       ((count_q == '0) || ((rsp_rd_i != '0) && !busy_o[rsp_rd_i]));
    assign rsp_dec   = rsp_valid_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            busy_o  <= '0;
        end else begin
            if (issue_fire && !rsp_dec) begin
                count_q <= count_q + CW'(1);
            end else if (!issue_fire && rsp_dec) begin
                count_q <= count_q - CW'(1);
            end
            if (rsp_valid_i) begin
                busy_o[rsp_rd_i] <= 1'b0;
            end
            if (issue_fire && (issue_rd_i != '0)) begin
                busy_o[issue_rd_i] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback merge of execute results and load responses; WB_SKID_EN adds an execute skid FIFO
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN            = XLEN_DEF,
    parameter int NREG            = NREG_DEF,
    parameter int MAX_OUTSTANDING = 2,
    parameter int SKID_DEPTH      = 2,
    localparam int RW             = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic            ex_we_i,
    input  logic [RW-1:0]   ex_rd_i,
    input  logic [1:0]      ex_wb_sel_i,
    input  logic [XLEN-1:0] ex_alu_data_i,
    input  logic [XLEN-1:0] ex_rd_data_i,
    input  logic [XLEN-1:0] ex_ret_addr_i,
    input  logic            ld_issue_valid_i,
    input  logic [RW-1:0]   ld_issue_rd_i,
    output logic            ld_issue_ready_o,
    input  logic            mem_rsp_valid_i,
    input  logic [RW-1:0]   mem_rsp_rd_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            rf_we_o,
    output logic [RW-1:0]   rf_addr_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic [NREG-1:0] busy_o,
    output logic            wb_err_o
);

    typedef struct packed {
        logic            we;
        logic            err;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    logic            waw;
    logic            ex_fire;
    logic            ex_sel_err;
    logic [XLEN-1:0] ex_data;
    logic            rsp_err;
    wb_entry_t       ex_entry;
    wb_entry_t       rsp_entry;
    wb_entry_t       slot;
    logic            slot_valid;

    wb_scoreboard #(
        .NREG            (NREG),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (ld_issue_valid_i),
        .issue_rd_i    (ld_issue_rd_i),
        .issue_ready_o (ld_issue_ready_o),
        .rsp_valid_i   (mem_rsp_valid_i),
        .rsp_rd_i      (mem_rsp_rd_i),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy_o)
    );

    always_comb begin
        ex_data = '0;
        case (wb_src_t'(ex_wb_sel_i))
            WB_ALU:          ex_data = ex_alu_data_i;
            WB_MEM:          ex_data = ex_rd_data_i;
            WB_PC_PLUS_FOUR: ex_data = ex_ret_addr_i;
            default:         ex_data = '0;
        endcase
    end

    assign ex_sel_err = (ex_wb_sel_i == 2'd3);
    assign waw        = ex_valid_i && ex_we_i && busy_o[ex_rd_i];
    assign ex_fire    = ex_valid_i && ex_ready_o;

    // Writes to x0 are consumed like any other but never raise rf_we_o.
    assign ex_entry.we    = ex_we_i && (ex_rd_i != '0) && !ex_sel_err;
    assign ex_entry.err   = ex_sel_err;
    assign ex_entry.rd    = ex_rd_i;
    assign ex_entry.data  = ex_data;

    assign rsp_entry.we   = (mem_rsp_rd_i != '0);
    assign rsp_entry.err  = rsp_err;
    assign rsp_entry.rd   = mem_rsp_rd_i;
    assign rsp_entry.data = mem_rsp_data_i;

`ifdef WB_SKID_EN
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    wb_entry_t     fifo_mem [SKID_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   fill_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == (PW + 1)'(SKID_DEPTH));
    assign ex_ready_o = !fifo_full && !waw;

    // An empty FIFO with a free slot lets the result bypass straight to the port.
    assign pop  = !mem_rsp_valid_i && !fifo_empty;
    assign push = ex_fire && (mem_rsp_valid_i || !fifo_empty);

    always_comb begin
        slot       = rsp_entry;
        slot_valid = 1'b0;
        if (mem_rsp_valid_i) begin
            slot       = rsp_entry;
            slot_valid = 1'b1;
        end else if (!fifo_empty) begin
            slot       = fifo_mem[head_q];
            slot_valid = 1'b1;
        end else if (ex_fire) begin
            slot       = ex_entry;
            slot_valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                tail_q <= next_ptr(tail_q);
            end
            if (pop) begin
                head_q <= next_ptr(head_q);
            end
            if (push && !pop) begin
                fill_q <= fill_q + (PW + 1)'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[tail_q] <= ex_entry;
        end
    end
`else
    assign ex_ready_o = !mem_rsp_valid_i && !waw;

    always_comb begin
        slot       = rsp_entry;
        slot_valid = 1'b0;
        if (mem_rsp_valid_i) begin
            slot       = rsp_entry;
            slot_valid = 1'b1;
        end else if (ex_fire) begin
            slot       = ex_entry;
            slot_valid = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
            wb_err_o  <= 1'b0;
        end else begin
            rf_we_o  <= slot_valid && slot.we;
            wb_err_o <= slot_valid && slot.err;
            if (slot_valid) begin
                rf_addr_o <= slot.rd;
                rf_data_o <= slot.data;
            end
        end
    end

endmodule
